// File: rtl/fifo_rr_merge.sv
// ============================================================================
// Module   : fifo_rr_merge
// Purpose  : Merges NUM_PORTS first-word-fall-through FIFO read ports into one
//            registered write stream, using burst-locked round-robin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_rr_merge #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int BURST_LEN  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            in_empty_n,
    output logic [NUM_PORTS-1:0]            in_read,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_dout,
    input  logic                            out_full_n,
    output logic                            out_write,
    output logic [DATA_WIDTH-1:0]           out_din,
    output logic [SEL_WIDTH-1:0]            out_src
);

    localparam logic [SEL_WIDTH-1:0] C_LAST_PORT = SEL_WIDTH'(NUM_PORTS - 1);
    localparam logic [7:0]           C_BURST_LEN = 8'(BURST_LEN);

    logic                  r_out_write;
    logic [DATA_WIDTH-1:0] r_out_din;
    logic [SEL_WIDTH-1:0]  r_out_src;
    logic [SEL_WIDTH-1:0]  r_last_grant;
    logic [7:0]            r_burst_cnt;
    logic                  r_locked;

    logic                  w_can_load;
    logic                  w_keep;
    logic                  w_rr_valid;
    logic [SEL_WIDTH-1:0]  w_rr_sel;
    logic                  w_sel_valid;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic [DATA_WIDTH-1:0] w_sel_word;
    logic [NUM_PORTS-1:0]  w_in_read;

    assign w_can_load = !r_out_write || out_full_n;
    assign w_keep     = r_locked && (r_burst_cnt < C_BURST_LEN) && in_empty_n[r_last_grant];

    // Rotating search starting just after the last grant; iterating from the
    // far end lets the nearest non-empty port overwrite earlier candidates.
    always_comb begin
        int idx;
        w_rr_valid = 1'b0;
        w_rr_sel   = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = (int'(r_last_grant) + i) % NUM_PORTS;
            if (in_empty_n[idx]) begin
                w_rr_valid = 1'b1;
                w_rr_sel   = SEL_WIDTH'(idx);
            end
        end
    end

    assign w_sel       = w_keep ? r_last_grant : w_rr_sel;
    assign w_sel_valid = w_keep || w_rr_valid;
    assign w_sel_word  = in_dout[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        w_in_read = '0;
        if (w_can_load && w_sel_valid && !reset) begin
            w_in_read[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_write  <= 1'b0;
            r_out_din    <= '0;
            r_out_src    <= '0;
            r_last_grant <= C_LAST_PORT;
            r_burst_cnt  <= 8'd0;
            r_locked     <= 1'b0;
        end else if (w_can_load) begin
            if (w_sel_valid) begin
                r_out_write <= 1'b1;
                r_out_din   <= w_sel_word;
                r_out_src   <= w_sel;
                if (w_keep) begin
                    r_burst_cnt <= r_burst_cnt + 8'd1;
                end else begin
                    r_last_grant <= w_sel;
                    r_burst_cnt  <= 8'd1;
                    r_locked     <= 1'b1;
                end
            end else begin
                // Nothing to load: drop the lock so a returning port re-arbitrates.
                r_out_write <= 1'b0;
                r_locked    <= 1'b0;
            end
        end
    end

    assign in_read   = w_in_read;
    assign out_write = r_out_write;
    assign out_din   = r_out_din;
    assign out_src   = r_out_src;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rr_merge.sv
// ============================================================================
// Module   : tb_fifo_rr_merge
// Purpose  : Self-checking bench for fifo_rr_merge (vector table, corner
//            sequences and randomized traffic against a queue-based model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_rr_merge;

    localparam int NP    = 4;
    localparam int DW    = 32;
    localparam int BURST = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     in_empty_n;
    logic [NP-1:0]     in_read, in_read_rr;
    logic [NP*DW-1:0]  in_dout;
    logic              out_full_n;
    logic              out_write, out_write_rr;
    logic [DW-1:0]     out_din, out_din_rr;
    logic [1:0]        out_src, out_src_rr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_rr_merge #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .SEL_WIDTH(2), .BURST_LEN(BURST)) u_dut (
        .clk(clk), .reset(reset), .in_empty_n(in_empty_n), .in_read(in_read),
        .in_dout(in_dout), .out_full_n(out_full_n), .out_write(out_write),
        .out_din(out_din), .out_src(out_src)
    );

    fifo_rr_merge #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .SEL_WIDTH(2), .BURST_LEN(1)) u_dut_rr (
        .clk(clk), .reset(reset), .in_empty_n(in_empty_n), .in_read(in_read_rr),
        .in_dout(in_dout), .out_full_n(out_full_n), .out_write(out_write_rr),
        .out_din(out_din_rr), .out_src(out_src_rr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model state (upstream FIFOs + arbiter) -----
    logic [31:0] q [NP][$];
    int          seq_in  [NP];
    int          seq_out [NP];
    int          n_in, n_out;
    int          m_owner, m_credit, m_pick, m_out_s;
    bit          m_owned, m_cont, m_can, m_out_v;
    logic [31:0] m_pick_word, m_out_w;
    logic [NP-1:0] prev_read;
    logic        prev_write, prev_full;
    logic [31:0] prev_din;
    logic [1:0]  prev_src;

    task automatic do_reset();
        reset      = 1'b1;
        in_empty_n = '0;
        in_dout    = '0;
        out_full_n = 1'b1;
        tick();
        reset = 1'b0;
        for (int p = 0; p < NP; p++) begin
            q[p].delete();
            seq_in[p]  = 0;
            seq_out[p] = 0;
        end
        n_in = 0; n_out = 0;
        m_owner = NP - 1; m_credit = 0; m_owned = 0; m_pick = -1; m_cont = 0;
        m_can = 0; m_out_v = 0; m_out_w = '0; m_out_s = 0; m_pick_word = '0;
        prev_read = '0; prev_write = 0; prev_full = 0; prev_din = '0; prev_src = '0;
    endtask

    // One randomized cycle; entered just after a rising edge.
    task automatic rnd_cycle(input bit drain);
        logic [NP-1:0] er;
        int p;
        if (prev_write && prev_full) begin
            p = int'(prev_src);
            check("order", prev_din, {8'(p), 24'(seq_out[p])});
            seq_out[p]++;
            n_out++;
        end
        for (int k = 0; k < NP; k++)
            if (prev_read[k] && q[k].size() > 0) void'(q[k].pop_front());
        if (m_can) begin
            if (m_pick >= 0) begin
                if (m_cont) m_credit--;
                else begin
                    m_owner = m_pick; m_credit = BURST - 1; m_owned = 1;
                end
                m_out_v = 1; m_out_w = m_pick_word; m_out_s = m_pick;
            end else begin
                m_out_v = 0; m_owned = 0;
            end
        end
        check("out_write", {31'd0, out_write}, {31'd0, m_out_v});
        if (m_out_v) begin
            check("out_din", out_din, m_out_w);
            check("out_src", {30'd0, out_src}, 32'(m_out_s));
        end
        if (!drain) begin
            for (int k = 0; k < NP; k++)
                if ($urandom_range(5) == 0 && q[k].size() < 16) begin
                    q[k].push_back({8'(k), 24'(seq_in[k])});
                    seq_in[k]++;
                    n_in++;
                end
        end
        out_full_n = drain ? 1'b1 : ($urandom_range(3) != 0);
        for (int k = 0; k < NP; k++) begin
            in_empty_n[k]          = (q[k].size() > 0);
            in_dout[k*DW +: DW]    = (q[k].size() > 0) ? q[k][0] : 32'h0;
        end
        #1;
        m_can  = !m_out_v || out_full_n;
        m_pick = -1;
        m_cont = 0;
        if (m_can) begin
            if (m_owned && m_credit > 0 && in_empty_n[m_owner]) begin
                m_pick = m_owner; m_cont = 1;
            end else begin
                for (int k = 1; k <= NP; k++)
                    if (m_pick < 0 && in_empty_n[(m_owner + k) % NP]) m_pick = (m_owner + k) % NP;
            end
        end
        er = '0;
        if (m_pick >= 0) begin
            er[m_pick]  = 1'b1;
            m_pick_word = q[m_pick][0];
        end
        check("in_read", {28'd0, in_read}, {28'd0, er});
        check("read_on_empty", {28'd0, in_read & ~in_empty_n}, 32'd0);
        prev_read  = in_read;
        prev_write = out_write;
        prev_full  = out_full_n;
        prev_din   = out_din;
        prev_src   = out_src;
        tick();
    endtask

    typedef struct {
        logic [NP-1:0] e;
        logic          f;
        logic [NP-1:0] rd;
        logic          w;
        logic [1:0]    s;
    } vec_t;

    vec_t tbl [16];

    initial begin
        bit done;
        // Burst rotation, stall, all-empty release, empty-mid-burst hand-off.
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[11] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[13] = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd2};
        tbl[14] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[15] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};

        do_reset();
        check("reset_write", {31'd0, out_write}, 32'd0);
        check("reset_din", out_din, 32'd0);
        check("reset_src", {30'd0, out_src}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            in_empty_n = tbl[i].e;
            out_full_n = tbl[i].f;
            for (int k = 0; k < NP; k++) in_dout[k*DW +: DW] = {8'(k), 24'(i)};
            #1;
            check($sformatf("tbl%0d_read", i), {28'd0, in_read}, {28'd0, tbl[i].rd});
            check($sformatf("tbl%0d_write", i), {31'd0, out_write}, {31'd0, tbl[i].w});
            check($sformatf("tbl%0d_src", i), {30'd0, out_src}, {30'd0, tbl[i].s});
            tick();
        end

        // Output stall holds the word; release accepts and reloads together.
        do_reset();
        in_empty_n = 4'b0001;
        in_dout[31:0] = 32'hA5A5A5A5;
        #1;
        check("stall_first_read", {28'd0, in_read}, 32'h1);
        tick();
        out_full_n    = 1'b0;
        in_dout[31:0] = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_read", {28'd0, in_read}, 32'h0);
            check("stall_din", out_din, 32'hA5A5A5A5);
            check("stall_write", {31'd0, out_write}, 32'h1);
            tick();
        end
        out_full_n    = 1'b1;
        in_dout[31:0] = 32'h11111111;
        #1;
        check("release_read", {28'd0, in_read}, 32'h1);
        tick();
        check("release_din", out_din, 32'h11111111);

        // Reset mid-burst on port 2.
        do_reset();
        in_empty_n = 4'b0100;
        tick();
        tick();
        check("pre_reset_src", {30'd0, out_src}, 32'd2);
        reset = 1'b1;
        #1;
        check("reset_in_read", {28'd0, in_read}, 32'h0);
        tick();
        reset = 1'b0;
        check("post_reset_write", {31'd0, out_write}, 32'h0);
        in_empty_n = 4'b0110;
        #1;
        check("post_reset_grant", {28'd0, in_read}, 32'h2);
        tick();
        check("post_reset_src", {30'd0, out_src}, 32'd1);

        // BURST_LEN=1 instance: pure alternation between ports 1 and 3.
        do_reset();
        in_empty_n = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_read", {28'd0, in_read_rr}, (i % 2 == 0) ? 32'h2 : 32'h8);
            if (i > 0) check("rr_src", {30'd0, out_src_rr}, (i % 2 == 1) ? 32'd1 : 32'd3);
            tick();
        end

        // Randomized traffic, then drain.
        do_reset();
        for (int c = 0; c < 10000; c++) rnd_cycle(1'b0);
        done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            rnd_cycle(1'b1);
            done = (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) && !prev_write;
        end
        check("drain_done", {31'd0, done}, 32'd1);
        check("words_in_eq_out", n_out, n_in);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_rr_merge.md
FIFO_RR_MERGE -- requirements
Module: fifo_rr_merge

Interface — parameters
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each data word.
REQ-002 SHALL have parameter NUM_PORTS, default 4, number of upstream FWFT FIFO read interfaces merged; legal range 2..16.
REQ-003 SHALL have parameter SEL_WIDTH, default 2, width of the source index; SHALL equal clog2(NUM_PORTS).
REQ-004 SHALL have parameter BURST_LEN, default 4, maximum consecutive words granted to one port before re-arbitration; legal range 1..255.

Interface — ports
REQ-005 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_empty_n, input, NUM_PORTS, bit p high = upstream FIFO p holds a word on its dout.
REQ-008 SHALL have port in_read, output, NUM_PORTS, bit p = pop upstream FIFO p this cycle.
REQ-009 SHALL have port in_dout, input, NUM_PORTS*DATA_WIDTH, port p data at bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port out_full_n, input, 1, downstream FIFO can accept a word.
REQ-011 SHALL have port out_write, output, 1, output word valid.
REQ-012 SHALL have port out_din, output, DATA_WIDTH, output word.
REQ-013 SHALL have port out_src, output, SEL_WIDTH, index of the port that supplied out_din.

Function
REQ-014 SHALL contain one output register (out_write, out_din, out_src); a transfer occurs on any cycle with out_write=1 and out_full_n=1.
REQ-015 SHALL define can_load = !out_write || out_full_n (combinational); in_read SHALL be all-zero whenever can_load=0.
REQ-016 in_read SHALL be zero or one-hot, and bit p SHALL assert only when in_empty_n[p]=1.
REQ-017 SHALL hold state: last_grant (SEL_WIDTH), burst_cnt (8 bits), locked (1).
REQ-018 When can_load=1, locked=1, burst_cnt<BURST_LEN and in_empty_n[last_grant]=1, SHALL select last_grant and increment burst_cnt.
REQ-019 Otherwise when can_load=1, SHALL select the first p with in_empty_n[p]=1 searching last_grant+1, +2, ... modulo NUM_PORTS (last_grant itself searched last), set last_grant=p, burst_cnt=1, locked=1; re-arbitration SHALL insert no bubble.
REQ-020 On selection of p: in_read[p]=1 that cycle; next cycle out_write=1, out_din=in_dout word p, out_src=p (latency 1 cycle, throughput 1 word/cycle).
REQ-021 When can_load=1 and in_empty_n all zero: in_read=0, out_write<=0 next cycle, locked<=0, last_grant held.
REQ-022 When can_load=0 (stall): out_write, out_din, out_src, last_grant, burst_cnt, locked SHALL all hold.
REQ-023 When burst_cnt==BURST_LEN at a load opportunity, the lock SHALL release and REQ-019 SHALL apply; with BURST_LEN=1 arbitration is pure per-word round-robin.
REQ-024 A port that goes empty mid-burst loses the lock; re-asserting in_empty_n later SHALL NOT resume its burst.
REQ-025 No word SHALL be lost, duplicated, or reordered within a port; words from different ports may interleave only at grant boundaries.

Reset
REQ-026 On reset=1 at a rising edge: out_write=0, out_din=0, out_src=0, last_grant=NUM_PORTS-1, burst_cnt=0, locked=0.
REQ-027 in_read SHALL be all-zero in any cycle where reset=1.
REQ-028 Reset mid-operation SHALL discard the word held in the output register; upstream words not yet read are unaffected.
REQ-029 First grant after reset with all ports non-empty SHALL go to port 0.

Verification
REQ-030 NUM_PORTS=4, BURST_LEN=4, all ports hold 8 words, out_full_n=1 -> out_src sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0..., one word per cycle, no bubbles.
REQ-031 BURST_LEN=4, only port 2 non-empty with 3 words, then port 1 gets 2 words -> out_src 2,2,2 then 1,1 with no bubble at the switch; no burst resume for port 2.
REQ-032 Output valid with word 0xA5A5A5A5, out_full_n=0 for 5 cycles -> out_din stable, in_read all-zero for 5 cycles; word accepted on the first cycle out_full_n=1, next word loaded the same cycle.
REQ-033 BURST_LEN=1, ports 1 and 3 continuously non-empty -> out_src alternates 1,3,1,3; ports 0 and 2 never read.
REQ-034 reset asserted for 1 cycle while out_write=1 mid-burst on port 2 -> next cycle out_write=0, in_read=0; after release first grant to lowest non-empty port from 0.
REQ-035 Random stimulus (random in_empty_n, random out_full_n, 10k cycles) -> scoreboard: per-port order preserved, word count in = out, in_read never set on an empty port or during stall.
